// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - Common data bus arbiter with a registered broadcast stage
//
// Each cycle this block picks up to NUM_CDB valid functional-unit results and
// grants them. The granted packets are registered onto the broadcast ports on
// the same edge that advances the FU output registers, so a grant is seen on
// cdb_ports exactly one cycle later.
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - asynchronous active-high reset
//   flush        - synchronous pipeline flush: no grants, empty broadcast
//   fu_results   - per-FU registered result; a request when is_valid is 1
//   fu_cdb_gnts  - per-FU grant, combinational from requests, flush and pointer
//   cdb_ports    - registered broadcast packets, one per common data bus
//
// Build option CDB_RR_PRIORITY_EN:
//   defined   - round-robin: scan starts at rr_ptr, which moves past the last
//               granted FU after every edge that grants without flush
//   undefined - fixed priority: scan always starts at FU 0; no pointer state

package cdb_pkg;
    typedef struct packed {
        logic        is_valid;
        logic [5:0]  rob_tag;
        logic [31:0] data;
    } writeback_packet_t;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU  = 5,
    parameter int NUM_CDB = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  writeback_packet_t fu_results [NUM_FU],
    output logic [NUM_FU-1:0] fu_cdb_gnts,
    output writeback_packet_t cdb_ports  [NUM_CDB]
);
    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [IDX_W-1:0]   scan_base;
    logic [NUM_FU-1:0]  gnt;
    logic [IDX_W-1:0]   port_src  [NUM_CDB];
    logic [NUM_CDB-1:0] port_used;
`ifdef CDB_RR_PRIORITY_EN
    logic [IDX_W-1:0]   last_gnt;
`endif

    writeback_packet_t  cdb_ports_d [NUM_CDB];
    writeback_packet_t  cdb_ports_q [NUM_CDB];

    // Scan all FUs starting at scan_base, wrapping past NUM_FU-1. The n-th
    // grant found is steered to broadcast port n.
    always_comb begin : scan
        int               n;
        int               idx;
        logic [IDX_W-1:0] idx_v;
        gnt       = '0;
        port_used = '0;
        n         = 0;
        idx       = 0;
        idx_v     = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            port_src[k] = '0;
        end
`ifdef CDB_RR_PRIORITY_EN
        last_gnt = '0;
`endif
        for (int i = 0; i < NUM_FU; i++) begin
            idx = int'(scan_base) + i;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end
            idx_v = IDX_W'(idx);
            if (fu_results[idx_v].is_valid && (n < NUM_CDB)) begin
                gnt[idx_v] = 1'b1;
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (k == n) begin
                        port_src[k]  = idx_v;
                        port_used[k] = 1'b1;
                    end
                end
`ifdef CDB_RR_PRIORITY_EN
                last_gnt = idx_v;
`endif
                n = n + 1;
            end
        end
    end

    // Grants are suppressed outright during reset and flush so no FU advances
    // its output register while the broadcast is being discarded.
    always_comb begin : gnt_out
        fu_cdb_gnts = gnt;
        if (flush || rst) begin
            fu_cdb_gnts = '0;
        end
    end

    always_comb begin : next_ports
        for (int k = 0; k < NUM_CDB; k++) begin
            cdb_ports_d[k] = '0;
            if (!flush && port_used[k]) begin
                cdb_ports_d[k] = fu_results[port_src[k]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_ports_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_ports_q[k] <= cdb_ports_d[k];
            end
        end
    end

    assign cdb_ports = cdb_ports_q;

`ifdef CDB_RR_PRIORITY_EN
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W-1:0] rr_ptr_q;

    // Flush leaves the pointer alone so fairness survives a squash.
    always_comb begin : next_ptr
        rr_ptr_d = rr_ptr_q;
        if (!flush && (|gnt)) begin
            if (int'(last_gnt) == NUM_FU - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = last_gnt + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign scan_base = rr_ptr_q;
`else
    assign scan_base = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - Scoreboard testbench for cdb_arbiter
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NF = 5;
    localparam int NC = 2;

    typedef struct {
        writeback_packet_t p0;
        writeback_packet_t p1;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              flush;
    writeback_packet_t cur_pkt   [NF];
    logic [NF-1:0]     fu_cdb_gnts;
    writeback_packet_t cdb_ports [NC];

    exp_t exp_q[$];
    int   n_chk;
    int   n_pass;
    int   m_ptr;

    cdb_arbiter #(.NUM_FU(NF), .NUM_CDB(NC)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fu_results  (cur_pkt),
        .fu_cdb_gnts (fu_cdb_gnts),
        .cdb_ports   (cdb_ports)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, act=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic set_inputs(input logic [NF-1:0] v, input logic fl);
        for (int i = 0; i < NF; i++) begin
            cur_pkt[i].is_valid = v[i];
            cur_pkt[i].rob_tag  = 6'($urandom);
            cur_pkt[i].data     = $urandom;
        end
        flush = fl;
    endtask

    // Drive one cycle of requests, check the grant vector, and queue the
    // broadcast expected after the coming rising edge (-1 = port unused).
    task automatic issue(input string nm, input logic [NF-1:0] v, input logic fl,
                         input logic [NF-1:0] eg, input int e0, input int e1);
        exp_t e;
        @(negedge clk);
        set_inputs(v, fl);
        #1;
        chk({nm, "_gnt"}, 64'(fu_cdb_gnts), 64'(eg));
        e.p0 = (e0 < 0) ? '0 : cur_pkt[e0];
        e.p1 = (e1 < 0) ? '0 : cur_pkt[e1];
        exp_q.push_back(e);
    endtask

    // Reference arbiter for the random phase.
    task automatic model_arb(input logic [NF-1:0] v, input logic fl,
                             output logic [NF-1:0] g, output int p0, output int p1);
        int n;
        int idx;
        int start;
        g  = '0;
        p0 = -1;
        p1 = -1;
        n  = 0;
`ifdef CDB_RR_PRIORITY_EN
        start = m_ptr;
`else
        start = 0;
`endif
        if (!fl) begin
            for (int k = 0; k < NF; k++) begin
                idx = (start + k) % NF;
                if (v[idx] && n < NC) begin
                    g[idx] = 1'b1;
                    if (n == 0) p0 = idx;
                    else        p1 = idx;
                    n = n + 1;
                end
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cdb_port0", 64'(cdb_ports[0]), 64'(e.p0));
                chk("cdb_port1", 64'(cdb_ports[1]), 64'(e.p1));
            end
        end
    end

    initial begin : stim
        logic [NF-1:0] req;
        logic [NF-1:0] g;
        logic [NF-1:0] g_prev;
        int            wait_cnt [NF];
        int            p0;
        int            p1;
        int            last;
        logic          fl;

        n_chk  = 0;
        n_pass = 0;
        m_ptr  = 0;
        rst    = 1'b1;
        set_inputs(5'b11111, 1'b0);
        #2;
        chk("reset_gnt", 64'(fu_cdb_gnts), 64'd0);
        chk("reset_port0", 64'(cdb_ports[0]), 64'd0);
        chk("reset_port1", 64'(cdb_ports[1]), 64'd0);
        set_inputs(5'b00000, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        issue("first_scan", 5'b00111, 1'b0, 5'b00011, 0, 1);
`ifdef CDB_RR_PRIORITY_EN
        issue("rr_retry",   5'b00101, 1'b0, 5'b00101, 2, 0);
        issue("flush",      5'b11111, 1'b1, 5'b00000, -1, -1);
        issue("ptr_kept",   5'b11111, 1'b0, 5'b00110, 1, 2);
        issue("fu3_only",   5'b01000, 1'b0, 5'b01000, 3, -1);
        issue("fu4_wrap",   5'b10000, 1'b0, 5'b10000, 4, -1);
        issue("after_wrap", 5'b11111, 1'b0, 5'b00011, 0, 1);
        issue("idle",       5'b00000, 1'b0, 5'b00000, -1, -1);
        issue("wrap_order", 5'b00110, 1'b0, 5'b00110, 2, 1);
`else
        issue("fixed_retry", 5'b00101, 1'b0, 5'b00101, 0, 2);
        issue("flush",       5'b11111, 1'b1, 5'b00000, -1, -1);
        issue("fixed_all",   5'b11111, 1'b0, 5'b00011, 0, 1);
        issue("fu3_only",    5'b01000, 1'b0, 5'b01000, 3, -1);
        issue("fu4_only",    5'b10000, 1'b0, 5'b10000, 4, -1);
        issue("fixed_all2",  5'b11111, 1'b0, 5'b00011, 0, 1);
        issue("idle",        5'b00000, 1'b0, 5'b00000, -1, -1);
        issue("fixed_order", 5'b00110, 1'b0, 5'b00110, 1, 2);
`endif
        issue("rst_pre", 5'b00010, 1'b0, 5'b00010, 1, -1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_port0", 64'(cdb_ports[0]), 64'd0);
        chk("async_rst_port1", 64'(cdb_ports[1]), 64'd0);
        chk("async_rst_gnt", 64'(fu_cdb_gnts), 64'd0);
        set_inputs(5'b00000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        issue("post_rst", 5'b01010, 1'b0, 5'b01010, 1, 3);

        // Random phase from a clean reset; FU3 models an idle AGU slot.
        @(negedge clk);
        set_inputs(5'b00000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        m_ptr  = 0;
        req    = '0;
        g_prev = '0;
        for (int i = 0; i < NF; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            fl = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NF; i++) begin
                if (!(req[i] && !g_prev[i])) req[i] = 1'($urandom_range(0, 1));
            end
            req[3] = 1'b0;
            model_arb(req, fl, g, p0, p1);
            issue("stress", req, fl, g, p0, p1);
            chk("stress_gnt_count", 64'($countones(fu_cdb_gnts) <= NC), 64'd1);
            chk("stress_gnt_invalid", 64'(fu_cdb_gnts & ~req), 64'd0);
            if (p0 >= 0) begin
                last  = (p1 >= 0) ? p1 : p0;
                m_ptr = (last + 1) % NF;
            end
            for (int i = 0; i < NF; i++) begin
                if (g[i]) begin
`ifdef CDB_RR_PRIORITY_EN
                    chk("stress_fairness", 64'(wait_cnt[i] < NF), 64'd1);
`endif
                    wait_cnt[i] = 0;
                end else if (req[i] && !fl) begin
                    wait_cnt[i] = wait_cnt[i] + 1;
                end
            end
            g_prev = g;
        end

        @(negedge clk);
        set_inputs(5'b00000, 1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
